// File: rtl/comms_pkg.sv
// Shared serial-link definitions: frame FSM states, line levels and counter sizing.
// Used by both the transmitter and the receiver side.
package comms_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } comms_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // ceil(log2(n)), but never narrower than one bit so a ratio of 1 still has a counter
  function automatic int counterWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/baud_tick.sv
// Baud-period counter: counts 0..RATIO-1 while enabled and flags the last cycle of each bit.
// Shared by the transmitter and receiver.
module baud_tick
  import comms_pkg::*;
#(
  parameter int RATIO = 8
) (
  input  logic i_clk,
  input  logic i_rstN,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_wrap
);

  localparam int CNT_W = counterWidth(RATIO);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] r_count;

  assign o_wrap = i_enable && (r_count == LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= o_wrap ? '0 : r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/send.sv
// Serial frame transmitter: start bit, payload LSB first, stop bit; all outputs registered.
// Define SEND_PARITY_EN to insert an even-parity bit between the payload and the stop bit.
module send
  import comms_pkg::*;
#(
  parameter int REGISTER_SIZE  = 1024,
  parameter int CLK_BAUD_RATIO = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     start_in,
  input  logic [REGISTER_SIZE-1:0] register_in,
  output logic                     tx_out,
  output logic                     busy_out,
  output logic                     done_out
);

  localparam int BIT_W = counterWidth(REGISTER_SIZE);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(REGISTER_SIZE - 1);

  comms_state_e             r_state;
  comms_state_e             w_nextState;
  logic [REGISTER_SIZE-1:0] r_shift;
  logic [REGISTER_SIZE-1:0] w_shiftNext;
  logic [BIT_W-1:0]         r_bitCnt;
  logic [BIT_W-1:0]         w_bitCntNext;
  logic                     r_tx;
  logic                     w_txNext;
  logic                     r_busy;
  logic                     w_busyNext;
  logic                     r_done;
  logic                     w_doneNext;
  logic                     w_accept;
  logic                     w_baudEnable;
  logic                     w_baudWrap;

  assign w_accept     = (r_state == IDLE) && start_in;
  assign w_baudEnable = (r_state != IDLE);

  baud_tick #(
    .RATIO(CLK_BAUD_RATIO)
  ) u_baudTick (
    .i_clk   (clk_in),
    .i_rstN  (rst_n_in),
    .i_clear (w_accept),
    .i_enable(w_baudEnable),
    .o_wrap  (w_baudWrap)
  );

`ifdef SEND_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^register_in;
    end
  end
`endif

  // Next line level is chosen together with the transition so tx_out changes with the state
  always_comb begin
    w_nextState  = r_state;
    w_shiftNext  = r_shift;
    w_bitCntNext = r_bitCnt;
    w_txNext     = r_tx;
    w_busyNext   = r_busy;
    w_doneNext   = 1'b0;
    case (r_state)
      IDLE: begin
        w_txNext   = IDLE_LEVEL;
        w_busyNext = 1'b0;
        if (start_in) begin
          w_nextState  = START;
          w_shiftNext  = register_in;
          w_bitCntNext = '0;
          w_txNext     = START_LEVEL;
          w_busyNext   = 1'b1;
        end
      end
      START: begin
        if (w_baudWrap) begin
          w_nextState = DATA;
          w_txNext    = r_shift[0];
        end
      end
      DATA: begin
        if (w_baudWrap) begin
          if (r_bitCnt == LAST_BIT) begin
`ifdef SEND_PARITY_EN
            w_nextState = PARITY;
            w_txNext    = r_parity;
`else
            w_nextState = STOP;
            w_txNext    = STOP_LEVEL;
`endif
          end else begin
            w_bitCntNext = r_bitCnt + BIT_W'(1);
            w_shiftNext  = r_shift >> 1;
            w_txNext     = r_shift[1];
          end
        end
      end
`ifdef SEND_PARITY_EN
      PARITY: begin
        if (w_baudWrap) begin
          w_nextState = STOP;
          w_txNext    = STOP_LEVEL;
        end
      end
`endif
      STOP: begin
        if (w_baudWrap) begin
          w_nextState = IDLE;
          w_txNext    = IDLE_LEVEL;
          w_busyNext  = 1'b0;
          w_doneNext  = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_txNext    = IDLE_LEVEL;
        w_busyNext  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitCnt <= '0;
      r_tx     <= IDLE_LEVEL;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_shift  <= w_shiftNext;
      r_bitCnt <= w_bitCntNext;
      r_tx     <= w_txNext;
      r_busy   <= w_busyNext;
      r_done   <= w_doneNext;
    end
  end

  assign tx_out   = r_tx;
  assign busy_out = r_busy;
  assign done_out = r_done;

endmodule

// File: tb/tb_send.sv
// Directed bench for send: every cycle's {tx, busy, done} is predicted into a queue when a frame is driven.
// dutA runs at 4 clocks per bit, dutB at 1 clock per bit; both carry 8-bit payloads.
module tb_send;

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
  } obs_t;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       startA = 1'b0;
  logic       startB = 1'b0;
  logic [7:0] regA = 8'h00;
  logic [7:0] regB = 8'h00;
  logic       txA, busyA, doneA;
  logic       txB, busyB, doneB;

  obs_t expQ[$];
  int   total = 0;
  int   bad = 0;
  int   sel = 0;

  always #5 clk = ~clk;

  send #(.REGISTER_SIZE(8), .CLK_BAUD_RATIO(4)) dutA (
    .clk_in     (clk),
    .rst_n_in   (rstN),
    .start_in   (startA),
    .register_in(regA),
    .tx_out     (txA),
    .busy_out   (busyA),
    .done_out   (doneA)
  );

  send #(.REGISTER_SIZE(8), .CLK_BAUD_RATIO(1)) dutB (
    .clk_in     (clk),
    .rst_n_in   (rstN),
    .start_in   (startB),
    .register_in(regB),
    .tx_out     (txB),
    .busy_out   (busyB),
    .done_out   (doneB)
  );

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushEntry(input logic tx, input logic busy, input logic done);
    obs_t e;
    e.tx   = tx;
    e.busy = busy;
    e.done = done;
    expQ.push_back(e);
  endtask

  // Whole-frame prediction: line low for the start bit, payload LSB first, optional parity,
  // line high for the stop bit, then one idle cycle carrying the done pulse
  task automatic pushFrame(input logic [7:0] payload, input int ratio);
    repeat (ratio) pushEntry(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (ratio) pushEntry(payload[i], 1'b1, 1'b0);
    end
`ifdef SEND_PARITY_EN
    repeat (ratio) pushEntry(^payload, 1'b1, 1'b0);
`endif
    repeat (ratio) pushEntry(1'b1, 1'b1, 1'b0);
    pushEntry(1'b1, 1'b0, 1'b1);
  endtask

  task automatic pushIdle(input int n);
    repeat (n) pushEntry(1'b1, 1'b0, 1'b0);
  endtask

  task automatic applyStimulus(input logic [7:0] payload, input int which);
    if (which == 1) begin
      startB = 1'b1;
      regB   = payload;
      pushFrame(payload, 1);
    end else begin
      startA = 1'b1;
      regA   = payload;
      pushFrame(payload, 4);
    end
  endtask

  task automatic checkOutput(input string tag);
    obs_t observed;
    obs_t expected;
    observed = (sel == 1) ? {txB, busyB, doneB} : {txA, busyA, doneA};
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $error("[TB] FAIL %s check %0d: observed tx/busy/done=%b but no expectation queued", tag, total, observed);
    end else begin
      expected = expQ.pop_front();
      assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s check %0d: tx/busy/done observed=%b expected=%b", tag, total, observed, expected);
      end
    end
  endtask

  task automatic stepCheck(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      checkOutput(tag);
    end
  endtask

  task automatic drain(input string tag);
    stepCheck(tag, expQ.size());
  endtask

  initial begin
    $display("[TB] starting send bench");

    // Reset state on both instances
    tick();
    tick();
    pushIdle(1);
    sel = 0;
    checkOutput("reset_A");
    pushIdle(1);
    sel = 1;
    checkOutput("reset_B");
    sel = 0;
    rstN = 1'b1;
    pushIdle(2);
    stepCheck("idle_after_reset", 2);

    // Single 8'hA5 frame
    applyStimulus(8'hA5, 0);
    stepCheck("frame_A5", 1);
    startA = 1'b0;
    drain("frame_A5");
    pushIdle(3);
    stepCheck("idle_after_A5", 3);

    // start held high across two frames: 8'h00 then 8'hFF back to back
    applyStimulus(8'h00, 0);
    pushFrame(8'hFF, 4);
    stepCheck("b2b", 1);
    regA = 8'hFF;
    stepCheck("b2b", 41);
    startA = 1'b0;
    drain("b2b");
    pushIdle(3);
    stepCheck("idle_after_b2b", 3);

    // Reset mid-DATA with start asserted during reset, then a clean frame
    applyStimulus(8'hA5, 0);
    stepCheck("pre_reset", 1);
    startA = 1'b0;
    stepCheck("pre_reset", 14);
    rstN = 1'b0;
    startA = 1'b1;
    expQ.delete();
    pushIdle(1);
    stepCheck("reset_abort", 1);
    rstN = 1'b1;
    startA = 1'b0;
    pushIdle(5);
    stepCheck("after_abort", 5);
    applyStimulus(8'h5A, 0);
    stepCheck("post_reset_frame", 1);
    startA = 1'b0;
    drain("post_reset_frame");

    // Payload input changes mid-frame must not alter the transmitted bits
    applyStimulus(8'hA5, 0);
    stepCheck("reg_change", 1);
    startA = 1'b0;
    stepCheck("reg_change", 8);
    regA = 8'h3C;
    drain("reg_change");

    // Payload with odd weight (parity bit 1 when parity is built in)
    applyStimulus(8'h01, 0);
    stepCheck("frame_01", 1);
    startA = 1'b0;
    drain("frame_01");
    pushIdle(2);
    stepCheck("idle_after_01", 2);

    // One clock per bit
    sel = 1;
    applyStimulus(8'h81, 1);
    stepCheck("ratio1_81", 1);
    startB = 1'b0;
    drain("ratio1_81");
    pushIdle(2);
    stepCheck("ratio1_idle", 2);
    sel = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
